seq_rca: RTL and testbench
==========================

SEQ_RCA -- requirements
Module: seq_rca

Interface
REQ-001 Parameter WIDTH, default 16, operand and sum width in bits.
REQ-002 Parameter CHUNK, default 4, bits added per clock cycle; WIDTH SHALL be an integer multiple of CHUNK.
REQ-003 sysclk_125mhz  input  1  single clock; all state on its rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-low.
REQ-005 in_valid  input  1  operands present.
REQ-006 in_ready  output  1  block can accept operands.
REQ-007 a  input  WIDTH  operand A.
REQ-008 b  input  WIDTH  operand B.
REQ-009 cin  input  1  carry-in.
REQ-010 sub  input  1  subtract request; present only with SEQ_RCA_SUB_EN.
REQ-011 out_valid  output  1  result present.
REQ-012 out_ready  input  1  consumer accepts result.
REQ-013 sum  output  WIDTH  result, modulo 2^WIDTH.
REQ-014 cout  output  1  carry out of the MSB.
REQ-015 ovf  output  1  two's-complement overflow.
REQ-016 busy  output  1  high in ADD state.

Function
REQ-017 FSM states SHALL be IDLE, ADD and DONE.
REQ-018 in_ready SHALL be 1 only in IDLE; out_valid SHALL be 1 only in DONE.
REQ-019 Accept = in_valid && in_ready: a, b and cin (plus sub) SHALL be captured, chunk counter cleared, IDLE->ADD.
REQ-020 ADD SHALL add one CHUNK slice per cycle, LSB slice first, carry registered between slices.
REQ-021 After slice NCHUNK-1 (NCHUNK = WIDTH/CHUNK) -> DONE; out_valid SHALL rise exactly NCHUNK cycles after the accept edge.
REQ-022 sum, cout and ovf SHALL stay stable while out_valid && !out_ready.
REQ-023 out_valid && out_ready: DONE->IDLE; no same-cycle re-accept (one bubble cycle).
REQ-024 in_valid outside IDLE SHALL be ignored; no operand capture.
REQ-025 Wrap-around: sum = (a+b+cin) mod 2^WIDTH; cout = bit WIDTH of the full sum.
REQ-026 ovf SHALL equal carry into bit WIDTH-1 XOR cout.
REQ-027 The chunk counter SHALL be $clog2(NCHUNK) bits wide (minimum 1) and SHALL clear on every accept.
REQ-028 NCHUNK = 1 SHALL give a single-cycle ADD with out_valid one cycle after accept.

Reset
REQ-029 rst low SHALL asynchronously force IDLE, counter 0, carry 0, sum 0, cout 0, ovf 0, out_valid 0, busy 0, in_ready 1.
REQ-030 Reset mid-ADD or in DONE SHALL discard the operation; no out_valid follows.

Configuration
REQ-031 With SEQ_RCA_SUB_EN defined, the sub port SHALL exist; when sub=1 at accept, the captured b SHALL be ~b, cin is ignored and effective carry-in is 1; cout=1 means no borrow.
REQ-032 Without SEQ_RCA_SUB_EN, the sub port SHALL be absent and the block SHALL only add.

Structure
REQ-033 Package seq_rca_pkg SHALL hold the state enum type (IDLE/ADD/DONE) and the default WIDTH and CHUNK constants.
REQ-034 Sub-module rca_chunk SHALL be a combinational CHUNK-bit ripple-carry adder (a, b, ci -> s, co, carry into its MSB), instantiated once.
REQ-035 A WIDTH not a multiple of CHUNK, or CHUNK > WIDTH, SHALL cause an elaboration error.

Verification (WIDTH=16, CHUNK=4)
REQ-036 0x00FF+0x0001, cin=0 -> sum=0x0100, cout=0, ovf=0, out_valid 4 cycles after accept, busy high for those 4 cycles.
REQ-037 0xFFFF+0x0001 -> sum=0x0000, cout=1, ovf=0; then 0x7FFF+0x0001 -> sum=0x8000, cout=0, ovf=1.
REQ-038 out_ready held low 5 cycles in DONE, new in_valid pulsed meanwhile -> sum held, in_ready=0, second operands never captured.
REQ-039 rst low after 2 ADD cycles -> next cycle in_ready=1, out_valid=0; a fresh 0x1234+0x1111 then yields 0x2345.
REQ-040 SEQ_RCA_SUB_EN defined, 0x0005-0x0007 (sub=1) -> sum=0xFFFE, cout=0; 0x0007-0x0005 -> sum=0x0002, cout=1.

Source files
------------

// File: rtl/seq_rca_pkg.sv
// rtl/seq_rca_pkg.sv - shared types and defaults for the sequential ripple-carry adder
`timescale 1ns/1ps
package seq_rca_pkg;

    localparam int DEF_WIDTH = 16;
    localparam int DEF_CHUNK = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADD  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Slice counter width; a single-slice adder still needs a 1-bit counter
    function automatic int cnt_width(input int nchunk);
        return (nchunk <= 1) ? 1 : $clog2(nchunk);
    endfunction

endpackage

// File: rtl/rca_chunk.sv
// rtl/rca_chunk.sv - combinational W-bit ripple-carry adder slice
`timescale 1ns/1ps
module rca_chunk #(
    parameter int W = 4
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         ci,
    output logic [W-1:0] s,
    output logic         co,
    output logic         c_msb
);

    // Ripple the carry bit by bit; the carry entering the top bit is kept for overflow
    always_comb begin
        logic carry;
        carry = ci;
        s     = '0;
        c_msb = 1'b0;
        for (int i = 0; i < W; i++) begin
            if (i == W - 1) begin
                c_msb = carry;
            end
            s[i]  = a[i] ^ b[i] ^ carry;
            carry = (a[i] & b[i]) | (a[i] & carry) | (b[i] & carry);
        end
        co = carry;
    end

endmodule

// File: rtl/seq_rca.sv
// rtl/seq_rca.sv - multi-cycle ripple-carry adder, one CHUNK slice per clock (optional SEQ_RCA_SUB_EN adds subtract)
`timescale 1ns/1ps
module seq_rca
    import seq_rca_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CHUNK = DEF_CHUNK
) (
    input  logic             sysclk_125mhz,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
`ifdef SEQ_RCA_SUB_EN
    input  logic             sub,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             busy
);

    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int CNT_W  = cnt_width(NCHUNK);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(NCHUNK - 1);

    // Reject configurations that cannot be split into whole slices
    generate
        if ((CHUNK > WIDTH) || ((WIDTH % CHUNK) != 0)) begin : g_bad_cfg
            $error("seq_rca: WIDTH must be a non-zero multiple of CHUNK");
        end
    endgenerate

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             carry_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] sum_q;
    logic             cout_q;
    logic             ovf_q;
    logic             in_ready_q;
    logic             out_valid_q;
    logic             busy_q;

    logic [WIDTH-1:0] b_eff;
    logic             cin_eff;
    int               slice_lo;
    logic [CHUNK-1:0] a_sl;
    logic [CHUNK-1:0] b_sl;
    logic [CHUNK-1:0] s_sl;
    logic             co_sl;
    logic             cmsb_sl;

    // Subtraction is a + ~b + 1, so the operand is inverted once at capture
`ifdef SEQ_RCA_SUB_EN
    assign b_eff   = sub ? ~b : b;
    assign cin_eff = sub ? 1'b1 : cin;
`else
    assign b_eff   = b;
    assign cin_eff = cin;
`endif

    // Pick the operand slice addressed by the chunk counter
    always_comb begin
        slice_lo = int'(cnt) * CHUNK;
        a_sl     = a_q[slice_lo +: CHUNK];
        b_sl     = b_q[slice_lo +: CHUNK];
    end

    rca_chunk #(
        .W(CHUNK)
    ) u_chunk (
        .a    (a_sl),
        .b    (b_sl),
        .ci   (carry_q),
        .s    (s_sl),
        .co   (co_sl),
        .c_msb(cmsb_sl)
    );

    // Control FSM: capture operands, add one slice per cycle, hold result until taken
    always_ff @(posedge sysclk_125mhz or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            cnt         <= '0;
            carry_q     <= 1'b0;
            a_q         <= '0;
            b_q         <= '0;
            sum_q       <= '0;
            cout_q      <= 1'b0;
            ovf_q       <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid && in_ready_q) begin
                        a_q        <= a;
                        b_q        <= b_eff;
                        carry_q    <= cin_eff;
                        cnt        <= '0;
                        sum_q      <= '0;
                        cout_q     <= 1'b0;
                        ovf_q      <= 1'b0;
                        in_ready_q <= 1'b0;
                        busy_q     <= 1'b1;
                        state      <= ADD;
                    end
                end
                ADD: begin
                    sum_q[slice_lo +: CHUNK] <= s_sl;
                    carry_q                  <= co_sl;
                    if (cnt == LAST) begin
                        cout_q      <= co_sl;
                        ovf_q       <= cmsb_sl ^ co_sl;
                        busy_q      <= 1'b0;
                        out_valid_q <= 1'b1;
                        state       <= DONE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state       <= IDLE;
                    end
                end
                default: begin
                    out_valid_q <= 1'b0;
                    busy_q      <= 1'b0;
                    in_ready_q  <= 1'b1;
                    state       <= IDLE;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign busy      = busy_q;
    assign sum       = sum_q;
    assign cout      = cout_q;
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_seq_rca.sv
// tb/tb_seq_rca.sv - self-checking bench for seq_rca (WIDTH=16, CHUNK=4)
`timescale 1ns/1ps
module tb_seq_rca;

    localparam int W = 16;
    localparam int C = 4;
    localparam int N = W / C;

    logic         sysclk_125mhz = 1'b0;
    logic         rst           = 1'b0;
    logic         in_valid      = 1'b0;
    logic         in_ready;
    logic [W-1:0] a             = '0;
    logic [W-1:0] b             = '0;
    logic         cin           = 1'b0;
    logic         sub_i         = 1'b0;
`ifdef SEQ_RCA_SUB_EN
    logic         sub;
    assign sub = sub_i;
`endif
    logic         out_valid;
    logic         out_ready     = 1'b0;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
    logic         busy;

    seq_rca #(.WIDTH(W), .CHUNK(C)) dut (
        .sysclk_125mhz(sysclk_125mhz),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .a            (a),
        .b            (b),
        .cin          (cin),
`ifdef SEQ_RCA_SUB_EN
        .sub          (sub),
`endif
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .sum          (sum),
        .cout         (cout),
        .ovf          (ovf),
        .busy         (busy)
    );

    always #4 sysclk_125mhz = ~sysclk_125mhz;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         cin;
        logic         sub;
        logic [W-1:0] exp_sum;
        logic         exp_cout;
        logic         exp_ovf;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference: whole-word arithmetic, overflow from operand/result signs
    function automatic logic [W+1:0] model(input logic [W-1:0] x, input logic [W-1:0] y,
                                           input logic ci, input logic sb);
        logic [W-1:0] yy;
        logic         cc;
        logic [W:0]   full;
        logic         v;
        yy   = sb ? ~y : y;
        cc   = sb ? 1'b1 : ci;
        full = {1'b0, x} + {1'b0, yy} + {{W{1'b0}}, cc};
        v    = (x[W-1] == yy[W-1]) && (full[W-1] != x[W-1]);
        return {v, full[W], full[W-1:0]};
    endfunction

    task automatic run_op(input string name, input logic [W-1:0] xa, input logic [W-1:0] xb,
                          input logic xc, input logic xs, input int hold, input bit pulse,
                          input logic [W-1:0] e_sum, input logic e_cout, input logic e_ovf);
        int guard;
        int lat;
        int busy_cnt;
        int bad;
        @(negedge sysclk_125mhz);
        guard = 0;
        while (!in_ready && guard < 20) begin
            @(negedge sysclk_125mhz);
            guard++;
        end
        chk({name, " in_ready"}, 32'(in_ready), 32'd1);
        a        = xa;
        b        = xb;
        cin      = xc;
        sub_i    = xs;
        in_valid = 1'b1;
        @(negedge sysclk_125mhz);
        in_valid = 1'b0;
        a        = $urandom;
        b        = $urandom;
        lat      = 0;
        busy_cnt = 0;
        while (!out_valid && lat < 20) begin
            if (busy) busy_cnt++;
            @(negedge sysclk_125mhz);
            lat++;
        end
        chk({name, " latency"}, 32'(lat), 32'(N));
        chk({name, " busy cycles"}, 32'(busy_cnt), 32'(N));
        chk({name, " sum"}, 32'(sum), 32'(e_sum));
        chk({name, " cout"}, 32'(cout), 32'(e_cout));
        chk({name, " ovf"}, 32'(ovf), 32'(e_ovf));
        bad = 0;
        for (int i = 0; i < hold; i++) begin
            if (pulse) begin
                in_valid = 1'b1;
                a        = $urandom;
                b        = $urandom;
            end
            @(negedge sysclk_125mhz);
            if (sum !== e_sum || cout !== e_cout || ovf !== e_ovf ||
                out_valid !== 1'b1 || in_ready !== 1'b0 || busy !== 1'b0) bad++;
        end
        if (hold > 0) chk({name, " hold stable"}, 32'(bad), 32'd0);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge sysclk_125mhz);
        out_ready = 1'b0;
        chk({name, " released"}, {30'd0, out_valid, in_ready}, 32'b01);
        if (pulse) begin
            bad = 0;
            for (int i = 0; i < 3; i++) begin
                @(negedge sysclk_125mhz);
                if (busy !== 1'b0 || out_valid !== 1'b0) bad++;
            end
            chk({name, " no stale accept"}, 32'(bad), 32'd0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL global timeout: got running, expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        logic [W+1:0] m;
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        logic         rc;
        logic         rs;
        int           seen;

        vecs.push_back('{16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0});
        vecs.push_back('{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0});
        vecs.push_back('{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1});
        vecs.push_back('{16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1});
        vecs.push_back('{16'h0000, 16'h0000, 1'b1, 1'b0, 16'h0001, 1'b0, 1'b0});
        vecs.push_back('{16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 16'hFFFF, 1'b1, 1'b0});
        vecs.push_back('{16'h0FFF, 16'h0001, 1'b1, 1'b0, 16'h1001, 1'b0, 1'b0});
`ifdef SEQ_RCA_SUB_EN
        vecs.push_back('{16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0});
        vecs.push_back('{16'h0007, 16'h0005, 1'b0, 1'b1, 16'h0002, 1'b1, 1'b0});
        vecs.push_back('{16'h8000, 16'h0001, 1'b1, 1'b1, 16'h7FFF, 1'b1, 1'b1});
`endif

        // Reset state
        repeat (3) @(negedge sysclk_125mhz);
        chk("reset in_ready", 32'(in_ready), 32'd1);
        chk("reset out_valid", 32'(out_valid), 32'd0);
        chk("reset busy", 32'(busy), 32'd0);
        chk("reset sum", 32'(sum), 32'd0);
        chk("reset cout/ovf", {30'd0, cout, ovf}, 32'd0);
        rst = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            run_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].sub,
                   i % 3, 1'b0, vecs[i].exp_sum, vecs[i].exp_cout, vecs[i].exp_ovf);
        end

        // Result held in DONE while the consumer stalls and new operands are offered
        run_op("stall", 16'h4321, 16'h1111, 1'b0, 1'b0, 5, 1'b1, 16'h5432, 1'b0, 1'b0);

        // Reset two cycles into ADD discards the operation
        @(negedge sysclk_125mhz);
        a        = 16'hAAAA;
        b        = 16'h5555;
        in_valid = 1'b1;
        @(negedge sysclk_125mhz);
        in_valid = 1'b0;
        @(negedge sysclk_125mhz);
        rst = 1'b0;
        #1;
        chk("midreset in_ready", 32'(in_ready), 32'd1);
        chk("midreset out_valid", 32'(out_valid), 32'd0);
        chk("midreset busy/sum", {15'd0, busy, sum}, 32'd0);
        @(negedge sysclk_125mhz);
        rst  = 1'b1;
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge sysclk_125mhz);
            if (out_valid || busy) seen++;
        end
        chk("midreset no result", 32'(seen), 32'd0);
        run_op("post reset", 16'h1234, 16'h1111, 1'b0, 1'b0, 0, 1'b0, 16'h2345, 1'b0, 1'b0);

        // Randomised operands against the arithmetic model
        for (int i = 0; i < 24; i++) begin
            ra = W'($urandom);
            rb = W'($urandom);
            rc = 1'($urandom_range(0, 1));
`ifdef SEQ_RCA_SUB_EN
            rs = 1'($urandom_range(0, 1));
`else
            rs = 1'b0;
`endif
            m = model(ra, rb, rc, rs);
            run_op($sformatf("rand%0d", i), ra, rb, rc, rs, $urandom_range(0, 2),
                   1'($urandom_range(0, 1)), m[W-1:0], m[W], m[W+1]);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
